// File: rtl/demux4_router_if.sv
// demux4_router_if
//   Bundles the producer-side and consumer-side handshake signals of the
//   1-to-4 demultiplexer.
//   Ports (signals):
//     S        channel select (producer -> router)
//     D        data word (producer -> router)
//     D_valid  producer presents a word
//     D_ready  router accepts a word for channel S this cycle
//     Y0..Y3   head-of-FIFO data per channel (router -> consumers)
//     Y_valid  per-channel non-empty flags
//     Y_ready  per-channel consumer take strobes
//   Modports: slave = router side, master = producer/consumer side.
interface demux4_router_if #(
  parameter int WIDTH = 1
);
  logic [1:0]       S;
  logic [WIDTH-1:0] D;
  logic             D_valid;
  logic             D_ready;
  logic [WIDTH-1:0] Y0;
  logic [WIDTH-1:0] Y1;
  logic [WIDTH-1:0] Y2;
  logic [WIDTH-1:0] Y3;
  logic [3:0]       Y_valid;
  logic [3:0]       Y_ready;

  modport slave (
    input  S, D, D_valid, Y_ready,
    output D_ready, Y0, Y1, Y2, Y3, Y_valid
  );

  modport master (
    output S, D, D_valid, Y_ready,
    input  D_ready, Y0, Y1, Y2, Y3, Y_valid
  );
endinterface

// File: rtl/demux4_router.sv
// demux4_router
//   Routes one input stream into four independent per-channel FIFOs chosen
//   by a 2-bit select; each channel drains with its own valid/ready pair.
//   Ports:
//     clk        single clock, rising edge
//     rst_n      synchronous reset, active-low
//     bus        demux4_router_if.slave (S, D, D_valid, D_ready, Y0..Y3,
//                Y_valid, Y_ready)
//     cnt0..3    per-channel accepted-word counters
//   Build option: define DEMUX_CNT_EN to build saturating accepted-word
//   counters; when undefined, cnt0..cnt3 are constant 0 and no flops exist.
module demux4_router #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux4_router_if.slave     bus,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1,
  output logic [CNT_W-1:0]   cnt2,
  output logic [CNT_W-1:0]   cnt3
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [WIDTH-1:0] mem_q    [4][DEPTH];
  logic [WIDTH-1:0] mem_d    [4][DEPTH];
  logic [PW-1:0]    rd_ptr_q [4];
  logic [PW-1:0]    rd_ptr_d [4];
  logic [PW-1:0]    wr_ptr_q [4];
  logic [PW-1:0]    wr_ptr_d [4];
  logic [OW-1:0]    occ_q    [4];
  logic [OW-1:0]    occ_d    [4];
  logic [WIDTH-1:0] y_q      [4];
  logic [WIDTH-1:0] y_d      [4];

  logic [3:0] full;
  logic [3:0] valid;
  logic [3:0] push_ch;
  logic [3:0] pop_ch;
  logic       d_ready;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      full[k]  = (occ_q[k] == OW'(DEPTH));
      valid[k] = (occ_q[k] != '0);
    end
  end

  // Ready looks only at the selected channel's registered fill level, so a
  // same-cycle pop never opens a full channel.
  assign d_ready = !full[bus.S];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    y_d      = y_q;
    push_ch  = '0;
    pop_ch   = '0;
    for (int k = 0; k < 4; k++) begin
      push_ch[k] = bus.D_valid && d_ready && (bus.S == 2'(k));
      pop_ch[k]  = valid[k] && bus.Y_ready[k];
      if (push_ch[k]) begin
        mem_d[k][wr_ptr_q[k]] = bus.D;
        wr_ptr_d[k]           = wr_ptr_q[k] + 1'b1;
      end
      if (pop_ch[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
      end
      occ_d[k] = occ_q[k] + OW'(push_ch[k]) - OW'(pop_ch[k]);
      // Registered head: follows the next head word, holds when draining empty.
      if (occ_d[k] != '0) begin
        y_d[k] = mem_d[k][rd_ptr_d[k]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[k][j] <= '0;
        end
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        occ_q[k]    <= '0;
        y_q[k]      <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      y_q      <= y_d;
    end
  end

  assign bus.D_ready = d_ready;
  assign bus.Y_valid = valid;
  assign bus.Y0      = y_q[0];
  assign bus.Y1      = y_q[1];
  assign bus.Y2      = y_q[2];
  assign bus.Y3      = y_q[3];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (push_ch[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
  assign cnt2 = '0;
  assign cnt3 = '0;
`endif

endmodule
